// File: rtl/snake_pkg.sv
// Shared definitions for the snake step scheduler: state encoding and datapath widths.
package snake_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned LEVEL_W  = 8;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PAUSED = 3'd3;
  localparam logic [STATE_W-1:0] ST_OVER   = 3'd4;

endpackage

// File: rtl/snake_speed_ctl.sv
// Holds the step period and food level: loads start values on init, shortens the
// period toward a floor and saturates the level on each accepted food pulse.
module snake_speed_ctl
  import snake_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] TICKS_INIT = 16'd200,
  parameter logic [PERIOD_W-1:0] TICKS_MIN  = 16'd40,
  parameter logic [PERIOD_W-1:0] TICKS_DEC  = 16'd10,
  parameter logic [LEVEL_W-1:0]  LEVEL_MAX  = 8'd255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                food_en,
  output logic [PERIOD_W-1:0] period,
  output logic [LEVEL_W-1:0]  level
);

  logic signed [PERIOD_W:0] dec_s;
  logic [PERIOD_W-1:0]      period_d;
  logic [LEVEL_W-1:0]       level_d;

  // Next period/level; the subtraction is one bit wider and signed so it cannot wrap
  always_comb begin
    dec_s    = $signed({1'b0, period}) - $signed({1'b0, TICKS_DEC});
    period_d = period;
    level_d  = level;
    if (init) begin
      period_d = TICKS_INIT;
      level_d  = '0;
    end else if (food_en) begin
      if (dec_s < $signed({1'b0, TICKS_MIN})) begin
        period_d = TICKS_MIN;
      end else begin
        period_d = PERIOD_W'(dec_s);
      end
      if (level < LEVEL_MAX) begin
        level_d = level + LEVEL_W'(1);
      end
    end
  end

  // Period/level registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period <= TICKS_INIT;
      level  <= '0;
    end else begin
      period <= period_d;
      level  <= level_d;
    end
  end

endmodule

// File: rtl/snake_step_scheduler.sv
// Snake step scheduler: counts prescaler ticks to the current period, issues a
// one-cycle step request and waits for step_done. Pause support is compiled in
// only when SNAKE_SCHED_PAUSE_EN is defined.
module snake_step_scheduler
  import snake_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] TICKS_INIT = 16'd200,
  parameter logic [PERIOD_W-1:0] TICKS_MIN  = 16'd40,
  parameter logic [PERIOD_W-1:0] TICKS_DEC  = 16'd10,
  parameter logic [LEVEL_W-1:0]  LEVEL_MAX  = 8'd255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start,
  input  logic                pause,
  input  logic                food,
  input  logic                collision,
  input  logic                step_done,
  output logic                step,
  output logic                running,
  output logic                paused,
  output logic                game_over,
  output logic [PERIOD_W-1:0] period,
  output logic [LEVEL_W-1:0]  level,
  output logic                overrun
);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
  logic                overrun_d;
  logic                pend_q, pend_d;
  logic                pause_c;
  logic                init_c;
  logic                food_en_c;
  logic                tick_done_c;
  logic                step_c, running_c, paused_c, game_over_c;

`ifdef SNAKE_SCHED_PAUSE_EN
  assign pause_c = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_c      = 1'b0;
`endif

  // A tick completes the period when the incremented count reaches or passes it
  assign tick_done_c = tick &&
    (({1'b0, tick_cnt_q} + (PERIOD_W+1)'(1)) >= {1'b0, period});

  snake_speed_ctl #(
    .TICKS_INIT (TICKS_INIT),
    .TICKS_MIN  (TICKS_MIN),
    .TICKS_DEC  (TICKS_DEC),
    .LEVEL_MAX  (LEVEL_MAX)
  ) u_speed (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init_c),
    .food_en (food_en_c),
    .period  (period),
    .level   (level)
  );

  // State, tick counter, overrun and pending-pause registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      overrun    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      overrun    <= overrun_d;
      pend_q     <= pend_d;
    end
  end

  // Next state: collision beats food, food beats pause, pause beats tick;
  // step_done is a handshake and is never masked in WAIT
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    overrun_d  = overrun;
    pend_d     = pend_q;
    init_c     = 1'b0;
    food_en_c  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d    = ST_RUN;
          tick_cnt_d = '0;
          overrun_d  = 1'b0;
          pend_d     = 1'b0;
          init_c     = 1'b1;
        end
      end
      ST_RUN: begin
        if (collision) begin
          state_d = ST_OVER;
        end else if (food) begin
          food_en_c = 1'b1;
        end else if (pause_c) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          if (tick_done_c) begin
            tick_cnt_d = '0;
            state_d    = ST_WAIT;
          end else begin
            tick_cnt_d = tick_cnt_q + PERIOD_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (collision) begin
          state_d = ST_OVER;
        end else begin
          if (food) begin
            food_en_c = 1'b1;
          end else if (pause_c) begin
            pend_d = 1'b1;
          end else if (tick) begin
            if (tick_done_c) begin
              tick_cnt_d = '0;
              if (!step_done) begin
                overrun_d = 1'b1;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + PERIOD_W'(1);
            end
          end
          if (step_done) begin
            state_d = pend_d ? ST_PAUSED : ST_RUN;
            pend_d  = 1'b0;
          end
        end
      end
      ST_PAUSED: begin
        if (collision) begin
          state_d = ST_OVER;
        end else if (food) begin
          food_en_c = 1'b1;
        end else if (pause_c) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track it
  always_comb begin
    step_c      = (state_q == ST_RUN) && (state_d == ST_WAIT);
    running_c   = (state_d == ST_RUN) || (state_d == ST_WAIT);
`ifdef SNAKE_SCHED_PAUSE_EN
    paused_c    = (state_d == ST_PAUSED);
`else
    paused_c    = 1'b0;
`endif
    game_over_c = (state_d == ST_OVER);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step      <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      step      <= step_c;
      running   <= running_c;
      paused    <= paused_c;
      game_over <= game_over_c;
    end
  end

endmodule
